uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte sources using round-robin arbitration with optional per-packet locking.
- Sits between the master handler's response sources and the uart transmit port.
- Drives the uart's transmit/tx_byte inputs and sequences each byte off uart is_transmitting.
- Flags a transmitter that never starts.

Parameters:
- NUM_REQ, 4, number of requesters; 2 to 2**ID_W.
- ID_W, 2, width of grant_id.
- START_TIMEOUT, 16, cycles allowed after the transmit pulse for uart_is_transmitting to rise; 1 to 255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a byte pending
- req_byte  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i]
- req_lock  in  NUM_REQ  sampled with the byte; 1 = more bytes of this packet follow
- req_ready  out  NUM_REQ  one-cycle accept pulse; at most one bit set
- uart_transmit  out  1  one-cycle start pulse to the uart
- uart_tx_byte  out  8  byte presented to the uart; held stable from launch until done
- uart_is_transmitting  in  1  uart busy status
- grant_id  out  ID_W  index of the last accepted requester
- busy  out  1  state != IDLE
- locked  out  1  lock currently held by grant_id
- tx_timeout  out  1  one-cycle error pulse

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; req_ready=0, uart_transmit=0, uart_tx_byte=0, grant_id=0, locked=0, tx_timeout=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT_START, WAIT_DONE.
- IDLE:
  - Arbitrates only when uart_is_transmitting==0. This covers a reset that lands mid-byte.
  - Unlocked: the winner is the first valid index searching pointer+1, pointer+2, ... with wrap-around modulo NUM_REQ.
  - Locked: only requester grant_id is eligible. Others wait even if valid.
  - On a winner w, in the same edge:
    - req_ready[w]=1 for one cycle; latch req_byte[w] into uart_tx_byte.
    - grant_id=w, pointer=w, locked=req_lock[w].
    - Go to LAUNCH.
  - Accept latency: req_valid high at edge N (state IDLE, uart idle) gives req_ready high after edge N+1. The requester may change its byte/valid the cycle after req_ready.
- LAUNCH:
  - uart_transmit=1 for exactly one cycle.
  - Load the timeout counter with START_TIMEOUT, then go to WAIT_START.
- WAIT_START:
  - uart_is_transmitting==1 → WAIT_DONE.
  - Otherwise decrement the counter. When it reaches 0: tx_timeout=1 for one cycle, locked=0, go to IDLE. The byte is dropped, not retried.
- WAIT_DONE: uart_is_transmitting==0 → IDLE.
- Back-to-back: minimum of 2 idle-to-idle overhead cycles beyond the uart busy time.
- Lock release: when the owner's accepted byte has req_lock=0, locked clears at that acceptance. Lock is also cleared by timeout or reset.
- Simultaneous valids: resolved purely by pointer order. A requester never wins twice in a row while another is valid, unless locked.
- A requester dropping req_valid before acceptance is legal; it is simply not selected.

Decomposition:
- Shared package (uart_defines):
  - State encodings TX_ARB_IDLE/LAUNCH/WAIT_START/WAIT_DONE (2 bits).
  - Default START_TIMEOUT.
- One sub-module: rr_select.
  - Combinational round-robin priority picker: NUM_REQ request vector, pointer and lock mask in; one-hot winner and index out.
  - Reusable by the wishbone arbiters.

Test Plan:
- Single byte: req_valid[2]=1, byte 0x55, uart model busy 20 cycles.
  - req_ready[2] pulses once; uart_transmit pulses once with uart_tx_byte=0x55; grant_id=2; busy clears the cycle after is_transmitting falls.
- Fairness: all four valid continuously with bytes 0xA0..0xA3.
  - Launch order 0,1,2,3,0,1; exactly one req_ready per byte.
- Lock: req 1 sends 0x10,0x11,0x12 with lock=1,1,0 while req 0 is valid with 0x99.
  - Order 0x10,0x11,0x12,0x99; locked high until the 0x12 acceptance.
- Timeout: uart model never raises is_transmitting, START_TIMEOUT=16.
  - tx_timeout pulses 16 cycles after the uart_transmit pulse; state returns to IDLE; the next request is served normally.
- Reset mid-byte: assert rst during WAIT_DONE while the uart model stays busy 10 more cycles, with req 3 valid.
  - Outputs go to reset values immediately; no req_ready until is_transmitting falls; then req 0 has priority over req 3 if both are valid.
- Busy uart at idle: is_transmitting held 1 with req 0 valid.
  - No grant, no transmit pulse until it falls.

Source files
------------

// File: rtl/uart_defines.sv
// Shared definitions for the UART transmit arbiter and its helpers.
package uart_defines;

    typedef enum logic [1:0] {
        TX_ARB_IDLE       = 2'd0,
        TX_ARB_LAUNCH     = 2'd1,
        TX_ARB_WAIT_START = 2'd2,
        TX_ARB_WAIT_DONE  = 2'd3
    } tx_arb_state_t;

    localparam int START_TIMEOUT_DEF = 16;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first eligible request after ptr, wrapping.
// Zero latency; no backpressure (pure function of its inputs).
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_vld
);

    logic [NUM_REQ-1:0] elig;

    assign elig = req & mask;

    // Offset k=1 is the highest priority, k=NUM_REQ (ptr itself) the lowest.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!grant_vld && elig[j] && (((int'(ptr) + k) % NUM_REQ) == j)) begin
                    grant_vld = 1'b1;
                    grant[j]  = 1'b1;
                    grant_idx = ID_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources, with packet lock.
// Accept one cycle after valid when idle; requesters wait while the uart or the arbiter is busy.
module uart_tx_arbiter
    import uart_defines::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = 2,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_byte,
    input  logic [NUM_REQ-1:0]   req_lock,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_transmit,
    output logic [7:0]           uart_tx_byte,
    input  logic                 uart_is_transmitting,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 locked,
    output logic                 tx_timeout
);

    tx_arb_state_t        state, state_nxt;
    logic [ID_W-1:0]      ptr;
    logic [7:0]           cnt;
    logic [NUM_REQ-1:0]   lock_mask;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [ID_W-1:0]      pick_idx;
    logic                 pick_vld;
    logic [7:0]           pick_byte;
    logic                 pick_lock;
    logic                 accept;
    logic                 start_expire;

    // While locked only the current owner may be picked.
    always_comb begin
        lock_mask = '1;
        if (locked) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                lock_mask[j] = (grant_id == ID_W'(j));
            end
        end
    end

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_select (
        .req       (req_valid),
        .ptr       (ptr),
        .mask      (lock_mask),
        .grant     (pick_onehot),
        .grant_idx (pick_idx),
        .grant_vld (pick_vld)
    );

    always_comb begin
        pick_byte = '0;
        pick_lock = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick_onehot[j]) begin
                pick_byte = req_byte[8*j +: 8];
                pick_lock = req_lock[j];
            end
        end
    end

    assign accept       = (state == TX_ARB_IDLE) && !uart_is_transmitting && pick_vld;
    assign start_expire = (state == TX_ARB_WAIT_START) && !uart_is_transmitting && (cnt == 8'd1);
    assign busy         = (state != TX_ARB_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TX_ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TX_ARB_IDLE:       if (accept) state_nxt = TX_ARB_LAUNCH;
            TX_ARB_LAUNCH:     state_nxt = TX_ARB_WAIT_START;
            TX_ARB_WAIT_START: begin
                if (uart_is_transmitting) begin
                    state_nxt = TX_ARB_WAIT_DONE;
                end else if (start_expire) begin
                    state_nxt = TX_ARB_IDLE;
                end
            end
            TX_ARB_WAIT_DONE:  if (!uart_is_transmitting) state_nxt = TX_ARB_IDLE;
            default:           state_nxt = TX_ARB_IDLE;
        endcase
    end

    // The transmit pulse is raised on the accept edge so it is high throughout LAUNCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready     <= '0;
            uart_transmit <= 1'b0;
            uart_tx_byte  <= '0;
            grant_id      <= '0;
            ptr           <= ID_W'(NUM_REQ - 1);
            locked        <= 1'b0;
            tx_timeout    <= 1'b0;
            cnt           <= '0;
        end else begin
            req_ready     <= '0;
            uart_transmit <= 1'b0;
            tx_timeout    <= 1'b0;
            if (accept) begin
                req_ready     <= pick_onehot;
                uart_transmit <= 1'b1;
                uart_tx_byte  <= pick_byte;
                grant_id      <= pick_idx;
                ptr           <= pick_idx;
                locked        <= pick_lock;
            end
            if (state == TX_ARB_LAUNCH) begin
                cnt <= 8'(START_TIMEOUT);
            end else if ((state == TX_ARB_WAIT_START) && !uart_is_transmitting) begin
                cnt <= cnt - 8'd1;
                if (start_expire) begin
                    tx_timeout <= 1'b1;
                    locked     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart busy model and requester queues.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int ID_W          = 2;
    localparam int START_TIMEOUT = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_byte = '0;
    logic [NUM_REQ-1:0]   req_lock = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 uart_transmit;
    logic [7:0]           uart_tx_byte;
    logic                 uart_is_transmitting;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;
    logic                 locked;
    logic                 tx_timeout;

    uart_tx_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .ID_W          (ID_W),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_byte             (req_byte),
        .req_lock             (req_lock),
        .req_ready            (req_ready),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting),
        .grant_id             (grant_id),
        .busy                 (busy),
        .locked               (locked),
        .tx_timeout           (tx_timeout)
    );

    always #5 clk = ~clk;

    // Uart model: busy for busy_len cycles after it samples a transmit pulse.
    int   ucnt = 0;
    int   busy_len = 20;
    logic model_en = 1'b1;
    logic force_busy = 1'b0;

    always @(posedge clk) begin
        if (model_en && uart_transmit) ucnt <= busy_len;
        else if (ucnt != 0)            ucnt <= ucnt - 1;
    end

    assign uart_is_transmitting = force_busy || (ucnt != 0);

    logic [8:0] rq [NUM_REQ][$];
    logic [7:0] launched [$];
    int         acc_id [$];
    logic       acc_lock [$];
    int n_chk = 0, n_err = 0;
    int cyc = 0, n_ready = 0, n_tx = 0, n_to = 0, multi_ready = 0;
    int tx_cyc = 0, to_cyc = 0, ist_fall = 0, busy_fall = 0;
    logic prev_ist = 1'b0, prev_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int id, input logic lk, input logic [7:0] b);
        rq[id].push_back({lk, b});
    endtask

    // One cycle: observe outputs at the falling edge, then refresh requester drive.
    task automatic step();
        logic [8:0] h;
        @(negedge clk);
        cyc++;
        if ($countones(req_ready) > 1) multi_ready++;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req_ready[j]) begin
                n_ready++;
                acc_id.push_back(j);
                acc_lock.push_back(locked);
                if (rq[j].size() != 0) void'(rq[j].pop_front());
            end
        end
        if (uart_transmit) begin
            n_tx++;
            tx_cyc = cyc;
            launched.push_back(uart_tx_byte);
        end
        if (tx_timeout) begin
            n_to++;
            to_cyc = cyc;
        end
        if (prev_ist && !uart_is_transmitting) ist_fall = cyc;
        if (prev_busy && !busy) busy_fall = cyc;
        prev_ist  = uart_is_transmitting;
        prev_busy = busy;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (rq[j].size() != 0) begin
                h = rq[j][0];
                req_valid[j]       = 1'b1;
                req_byte[8*j +: 8] = h[7:0];
                req_lock[j]        = h[8];
            end else begin
                req_valid[j]       = 1'b0;
                req_byte[8*j +: 8] = 8'h00;
                req_lock[j]        = 1'b0;
            end
        end
    endtask

    function automatic logic drained();
        logic e;
        e = 1'b1;
        for (int j = 0; j < NUM_REQ; j++) if (rq[j].size() != 0) e = 1'b0;
        return e && !busy && !uart_is_transmitting;
    endfunction

    task automatic wait_drain(input string tag, input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!drained() && k < budget);
        check({tag, "_drain"}, 32'(drained()), 32'd1);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        model_en   = 1'b1;
        force_busy = 1'b0;
        busy_len   = 20;
        for (int j = 0; j < NUM_REQ; j++) rq[j].delete();
        launched.delete();
        acc_id.delete();
        acc_lock.delete();
        n_ready = 0;
        n_tx    = 0;
        n_to    = 0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  32'(req_ready), 32'd0);
        check({tag, "_xmit"},   32'(uart_transmit), 32'd0);
        check({tag, "_byte"},   32'(uart_tx_byte), 32'd0);
        check({tag, "_grant"},  32'(grant_id), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_tmo"},    32'(tx_timeout), 32'd0);
    endtask

    initial begin
        logic [7:0] fair_exp [6];
        int k, snap;
        fair_exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1};

        step();
        check_reset_outputs("rst0");
        do_reset();

        // Single byte from requester 2
        busy_len = 20;
        push(2, 1'b0, 8'h55);
        wait_drain("single", 100);
        check("single_ready_cnt", 32'(n_ready), 32'd1);
        check("single_tx_cnt", 32'(n_tx), 32'd1);
        check("single_byte", 32'(launched[0]), 32'h55);
        check("single_acc_id", 32'(acc_id[0]), 32'd2);
        check("single_grant", 32'(grant_id), 32'd2);
        check("single_busy_fall", 32'(busy_fall - ist_fall), 32'd1);

        // Fairness with all four continuously valid
        do_reset();
        busy_len = 5;
        push(0, 1'b0, 8'hA0); push(0, 1'b0, 8'hA0);
        push(1, 1'b0, 8'hA1); push(1, 1'b0, 8'hA1);
        push(2, 1'b0, 8'hA2);
        push(3, 1'b0, 8'hA3);
        wait_drain("fair", 200);
        check("fair_ready_cnt", 32'(n_ready), 32'd6);
        check("fair_tx_cnt", 32'(n_tx), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("fair_byte%0d", i), 32'(launched[i]), 32'(fair_exp[i]));

        // Locked packet from requester 1 while requester 0 waits
        do_reset();
        busy_len = 4;
        push(1, 1'b1, 8'h10); push(1, 1'b1, 8'h11); push(1, 1'b0, 8'h12);
        k = 0;
        while (n_ready == 0 && k < 30) begin
            step();
            k++;
        end
        check("lock_first_accept", 32'(n_ready), 32'd1);
        push(0, 1'b0, 8'h99);
        wait_drain("lock", 200);
        check("lock_b0", 32'(launched[0]), 32'h10);
        check("lock_b1", 32'(launched[1]), 32'h11);
        check("lock_b2", 32'(launched[2]), 32'h12);
        check("lock_b3", 32'(launched[3]), 32'h99);
        check("lock_l0", 32'(acc_lock[0]), 32'd1);
        check("lock_l1", 32'(acc_lock[1]), 32'd1);
        check("lock_l2", 32'(acc_lock[2]), 32'd0);
        check("lock_final", 32'(locked), 32'd0);

        // Transmitter never starts
        do_reset();
        model_en = 1'b0;
        push(2, 1'b1, 8'h42);
        k = 0;
        while (n_to == 0 && k < 80) begin
            step();
            k++;
        end
        check("tmo_count", 32'(n_to), 32'd1);
        check("tmo_gap_after_pulse", 32'(to_cyc - (tx_cyc + 1)), 32'(START_TIMEOUT));
        check("tmo_locked", 32'(locked), 32'd0);
        step();
        check("tmo_idle", 32'(busy), 32'd0);
        model_en = 1'b1;
        busy_len = 6;
        push(1, 1'b0, 8'h77);
        wait_drain("tmo_next", 100);
        check("tmo_next_byte", 32'(launched[1]), 32'h77);
        check("tmo_next_id", 32'(acc_id[1]), 32'd1);
        check("tmo_no_more", 32'(n_to), 32'd1);

        // Reset landing while the uart is mid-byte
        do_reset();
        model_en = 1'b0;
        push(2, 1'b0, 8'h5A);
        k = 0;
        while (n_tx == 0 && k < 20) begin
            step();
            k++;
        end
        force_busy = 1'b1;
        step(); step(); step();
        check("mid_in_wait_done", 32'(busy), 32'd1);
        push(3, 1'b0, 8'h33);
        step();
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        push(0, 1'b0, 8'h0F);
        step();
        step();
        rst = 1'b0;
        snap = n_ready;
        repeat (10) step();
        check("mid_no_grant_busy", 32'(n_ready - snap), 32'd0);
        force_busy = 1'b0;
        wait_drain("mid", 100);
        check("mid_first_id", 32'(acc_id[1]), 32'd0);
        check("mid_first_byte", 32'(launched[1]), 32'h0F);
        check("mid_second_id", 32'(acc_id[2]), 32'd3);
        check("mid_second_byte", 32'(launched[2]), 32'h33);

        // Uart already busy while idle
        do_reset();
        force_busy = 1'b1;
        busy_len = 5;
        push(0, 1'b0, 8'hC3);
        repeat (8) step();
        check("busyidle_no_ready", 32'(n_ready), 32'd0);
        check("busyidle_no_tx", 32'(n_tx), 32'd0);
        force_busy = 1'b0;
        wait_drain("busyidle", 100);
        check("busyidle_tx", 32'(n_tx), 32'd1);
        check("busyidle_byte", 32'(launched[0]), 32'hC3);

        check("ready_onehot", 32'(multi_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
